// File: rtl/exec_pkg.sv
// Shared types and defaults for the execute stage that sits after the 4x16 register file.
package exec_pkg;

    localparam int unsigned ExecWidth  = 16;
    localparam int unsigned ExecShamtW = 4;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpShr = 3'b110,
        OpMul = 3'b111
    } op_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_t;

endpackage

// File: rtl/exec_unit_if.sv
// Request/response bundle between the operand source and exec_unit.
interface exec_unit_if
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = ExecWidth
);
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             write_en;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, write_en, result, zero, carry
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, write_en, result, zero, carry
    );
endinterface

// File: rtl/exec_alu_comb.sv
// Combinational single-cycle ALU producing {carry, result}; MUL here means "unsupported"
// and yields result 0 with carry set.
module exec_alu_comb
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH   = ExecWidth,
    parameter int unsigned SHAMT_W = ExecShamtW
) (
    input  op_t              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;

    // One guard bit on each shift catches the last bit out; it stays 0 for shift by 0.
    always_comb begin
        shamt = b_i[SHAMT_W-1:0];
        sum   = {1'b0, a_i} + {1'b0, b_i};
        shl   = {1'b0, a_i} << shamt;
        shr   = {a_i, 1'b0} >> shamt;
    end

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OpAdd: {carry_o, result_o} = sum;
            OpSub: begin
                result_o = a_i - b_i;
                carry_o  = (a_i < b_i);
            end
            OpAnd: result_o = a_i & b_i;
            OpOr:  result_o = a_i | b_i;
            OpXor: result_o = a_i ^ b_i;
            OpShl: {carry_o, result_o} = shl;
            OpShr: {result_o, carry_o} = shr;
            OpMul: begin
                result_o = '0;
                carry_o  = 1'b1;
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: registered single-cycle ALU results plus an optional iterative shift-add MUL.
// Define EXEC_MUL_EN to build the multiplier; otherwise MUL completes at once flagged by carry.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH   = ExecWidth,
    parameter int unsigned SHAMT_W = ExecShamtW
) (
    input  logic      clk,
    input  logic      reset,
    exec_unit_if.slave bus
);
    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             accept;

    assign accept = (state_q == StIdle) && bus.start;

`ifdef EXEC_MUL_EN
    localparam logic [SHAMT_W-1:0] CntLast = SHAMT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_step;
    logic               mul_last;

    assign acc_step = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0);
    assign mul_last = (cnt_q == CntLast);
`endif

    exec_alu_comb #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .op_i     (bus.op),
        .a_i      (bus.operand_a),
        .b_i      (bus.operand_b),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
`ifdef EXEC_MUL_EN
                if (accept && (bus.op == OpMul)) state_d = StMul;
`endif
            end
            StMul: begin
`ifdef EXEC_MUL_EN
                if (mul_last) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
`ifdef EXEC_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && (bus.op == OpMul)) begin
            mcand_d  = bus.operand_a;
            mplier_d = bus.operand_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (accept) begin
            done_d   = 1'b1;
            result_d = alu_result;
            zero_d   = (alu_result == '0);
            carry_d  = alu_carry;
        end else if (state_q == StMul) begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (mul_last) begin
                done_d   = 1'b1;
                result_d = acc_step;
                zero_d   = (acc_step == '0);
                carry_d  = 1'b0;
            end
        end
`else
        if (accept) begin
            done_d   = 1'b1;
            result_d = alu_result;
            zero_d   = (alu_result == '0);
            carry_d  = alu_carry;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
`ifdef EXEC_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
`ifdef EXEC_MUL_EN
        bus.busy = (state_q == StMul);
`else
        bus.busy = 1'b0;
`endif
        bus.done     = done_q;
        bus.write_en = done_q;
        bus.result   = result_q;
        bus.zero     = zero_q;
        bus.carry    = carry_q;
    end
endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; inputs change and outputs are sampled on negedge.
module tb_exec_unit;
    import exec_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    exec_unit_if #(.WIDTH(16)) ifc ();

    exec_unit #(
        .WIDTH   (16),
        .SHAMT_W (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for one posedge, return at the negedge after it.
    task automatic issue(input op_t o, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        ifc.start     = 1'b1;
        ifc.op        = o;
        ifc.operand_a = a;
        ifc.operand_b = b;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ifc.result !== 16'h0000) begin errors++; $display("FAIL rst_result: got %h want 0000", ifc.result); end
        checks++; if ({ifc.busy, ifc.done, ifc.write_en, ifc.zero, ifc.carry} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {ifc.busy, ifc.done, ifc.write_en, ifc.zero, ifc.carry}); end
        issue(OpAdd, 16'h0005, 16'h0007);
        checks++; if (ifc.result !== 16'h000C) begin errors++; $display("FAIL pre_rst_add: got %h want 000c", ifc.result); end
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = OpOr; ifc.operand_a = 16'h1234; ifc.operand_b = 16'h0001;
        #2 reset = 1'b0;
        #1;
        checks++; if ({ifc.result, ifc.done, ifc.write_en, ifc.busy, ifc.zero, ifc.carry} !== 21'h0) begin errors++; $display("FAIL rst_mid: got result=%h flags=%b want all 0", ifc.result, {ifc.done, ifc.write_en, ifc.busy, ifc.zero, ifc.carry}); end
        @(negedge clk);
        ifc.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({ifc.result, ifc.done, ifc.busy} !== 18'h0) begin errors++; $display("FAIL rst_release: got result=%h done=%b busy=%b want 0", ifc.result, ifc.done, ifc.busy); end
    endtask

    task automatic test_add_sub();
        issue(OpAdd, 16'hFFFF, 16'h0001);
        checks++; if ({ifc.done, ifc.write_en} !== 2'b11) begin errors++; $display("FAIL add_done: got %b want 11", {ifc.done, ifc.write_en}); end
        checks++; if ({ifc.result, ifc.zero, ifc.carry} !== {16'h0000, 1'b1, 1'b1}) begin errors++; $display("FAIL add_ovf: got %h z=%b c=%b want 0000 z=1 c=1", ifc.result, ifc.zero, ifc.carry); end
        @(negedge clk);
        checks++; if ({ifc.done, ifc.write_en, ifc.result} !== 18'h0) begin errors++; $display("FAIL add_hold: got done=%b we=%b result=%h want 0 0 0000", ifc.done, ifc.write_en, ifc.result); end
        issue(OpSub, 16'h0003, 16'h0005);
        checks++; if ({ifc.done, ifc.result, ifc.zero, ifc.carry} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_borrow: got done=%b %h z=%b c=%b want 1 fffe 0 1", ifc.done, ifc.result, ifc.zero, ifc.carry); end
        issue(OpSub, 16'h0009, 16'h0004);
        checks++; if ({ifc.result, ifc.zero, ifc.carry} !== {16'h0005, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_plain: got %h z=%b c=%b want 0005 0 0", ifc.result, ifc.zero, ifc.carry); end
    endtask

    task automatic test_shift();
        issue(OpShr, 16'h8001, 16'h0001);
        checks++; if ({ifc.result, ifc.carry} !== {16'h4000, 1'b1}) begin errors++; $display("FAIL shr1: got %h c=%b want 4000 1", ifc.result, ifc.carry); end
        issue(OpShl, 16'h8001, 16'h0010);
        checks++; if ({ifc.result, ifc.carry, ifc.zero} !== {16'h8001, 1'b0, 1'b0}) begin errors++; $display("FAIL shl0: got %h c=%b z=%b want 8001 0 0", ifc.result, ifc.carry, ifc.zero); end
        issue(OpShl, 16'h8001, 16'h0001);
        checks++; if ({ifc.result, ifc.carry} !== {16'h0002, 1'b1}) begin errors++; $display("FAIL shl1: got %h c=%b want 0002 1", ifc.result, ifc.carry); end
        issue(OpShr, 16'h00F0, 16'h0005);
        checks++; if ({ifc.result, ifc.carry} !== {16'h0007, 1'b1}) begin errors++; $display("FAIL shr5: got %h c=%b want 0007 1", ifc.result, ifc.carry); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = OpAnd; ifc.operand_a = 16'hF0F0; ifc.operand_b = 16'hFF00;
        @(negedge clk);
        ifc.op = OpXor;
        checks++; if ({ifc.done, ifc.result, ifc.carry} !== {1'b1, 16'hF000, 1'b0}) begin errors++; $display("FAIL b2b_and: got done=%b %h c=%b want 1 f000 0", ifc.done, ifc.result, ifc.carry); end
        @(negedge clk);
        ifc.start = 1'b0;
        checks++; if ({ifc.done, ifc.result} !== {1'b1, 16'h0FF0}) begin errors++; $display("FAIL b2b_xor: got done=%b %h want 1 0ff0", ifc.done, ifc.result); end
        @(negedge clk);
        checks++; if ({ifc.done, ifc.result} !== {1'b0, 16'h0FF0}) begin errors++; $display("FAIL b2b_idle: got done=%b %h want 0 0ff0", ifc.done, ifc.result); end
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        int busy_cnt;
        int done_cnt;
        int overlap;
        logic [15:0] res;
        logic z;
        logic c;
        busy_cnt = 0; done_cnt = 0; overlap = 0; res = 16'hDEAD; z = 1'b1; c = 1'b1;
        issue(OpMul, 16'h0123, 16'h0045);
        for (int i = 0; i < 24; i++) begin
            if (ifc.busy) busy_cnt++;
            if (ifc.done) begin done_cnt++; res = ifc.result; z = ifc.zero; c = ifc.carry; end
            if (ifc.busy && ifc.done) overlap++;
            if (i == 2) begin
                ifc.start = 1'b1; ifc.op = OpAdd; ifc.operand_a = 16'h0001; ifc.operand_b = 16'h0001;
            end else if (i == 3) begin
                ifc.start = 1'b0; ifc.operand_a = 16'hFFFF; ifc.operand_b = 16'hFFFF;
            end
            @(negedge clk);
        end
        checks++; if (busy_cnt !== 16) begin errors++; $display("FAIL mul_busy_len: got %0d want 16", busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mul_done_cnt: got %0d want 1", done_cnt); end
        checks++; if ({res, z, c} !== {16'h4E6F, 1'b0, 1'b0}) begin errors++; $display("FAIL mul_result: got %h z=%b c=%b want 4e6f 0 0", res, z, c); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL mul_overlap: got %0d want 0", overlap); end
        checks++; if (ifc.result !== 16'h4E6F) begin errors++; $display("FAIL mul_hold: got %h want 4e6f", ifc.result); end
    endtask

    task automatic test_mul_reset();
        int done_cnt;
        int busy_cnt;
        done_cnt = 0; busy_cnt = 0;
        issue(OpMul, 16'h00FF, 16'h00FF);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if ({ifc.busy, ifc.done, ifc.result} !== 18'h0) begin errors++; $display("FAIL mulrst_now: got busy=%b done=%b %h want 0 0 0000", ifc.busy, ifc.done, ifc.result); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ifc.done) done_cnt++;
            if (ifc.busy) busy_cnt++;
            @(negedge clk);
        end
        checks++; if ({done_cnt, busy_cnt} !== 64'h0) begin errors++; $display("FAIL mulrst_after: got done=%0d busy=%0d want 0 0", done_cnt, busy_cnt); end
    endtask
`else
    task automatic test_mul_stub();
        int busy_cnt;
        busy_cnt = 0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.op = OpMul; ifc.operand_a = 16'h0123; ifc.operand_b = 16'h0045;
        if (ifc.busy) busy_cnt++;
        @(negedge clk);
        ifc.start = 1'b0;
        checks++; if ({ifc.done, ifc.write_en, ifc.result, ifc.zero, ifc.carry} !== {2'b11, 16'h0000, 2'b11}) begin errors++; $display("FAIL mulstub: got done=%b we=%b %h z=%b c=%b want 1 1 0000 1 1", ifc.done, ifc.write_en, ifc.result, ifc.zero, ifc.carry); end
        for (int i = 0; i < 4; i++) begin
            if (ifc.busy) busy_cnt++;
            @(negedge clk);
        end
        checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL mulstub_pulse: got done=%b want 0", ifc.done); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL mulstub_busy: got %0d want 0", busy_cnt); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0;
        ifc.start = 1'b0;
        ifc.op = OpAdd;
        ifc.operand_a = '0;
        ifc.operand_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_add_sub();
        test_shift();
        test_back_to_back();
`ifdef EXEC_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_stub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the 4-entry 16-bit register file.
- Consumes the two registered read operands and an opcode, and produces a result plus a one-cycle write strobe for the register file's write_data/write inputs.
- Single-cycle ALU ops complete in one cycle.
- MUL is an iterative shift-add that runs for WIDTH cycles under a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width; must match the register file data width.
- SHAMT_W, 4, number of operand_b LSBs used as the shift amount (log2 WIDTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on posedge only while busy=0.
- op  in  3  opcode (encodings in package).
- operand_a  in  WIDTH  first operand (register file data1).
- operand_b  in  WIDTH  second operand / shift amount (register file data2).
- busy  out  1  high while a MUL is in progress.
- done  out  1  one-cycle pulse: result and flags are updated this cycle.
- write_en  out  1  equals done; drives the register file write input.
- result  out  WIDTH  last completed result; held until the next done.
- zero  out  1  result == 0 for the last completed op.
- carry  out  1  carry/borrow/shifted-out bit for the last completed op.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, write_en, result, zero and carry all 0; MUL accumulator and counter cleared.
- States:
  - IDLE: accepts start.
  - MUL: iterating.
  - There is no separate DONE state; done is a registered pulse.
- IDLE, start=1, op!=MUL:
  - Operands are captured on edge E0.
  - result, zero, carry and done=1 are visible after E0; done drops after E0+1.
  - Latency is 1 cycle. A start on consecutive cycles gives back-to-back done pulses.
- IDLE, start=1, op=MUL:
  - Operands are captured; counter=0; accumulator=0; busy=1 after E0.
  - Each cycle: if multiplier bit[counter] is set, acc += multiplicand<<counter (mod 2^WIDTH); counter increments.
  - After edge E0+WIDTH: busy=0, done=1, result = low WIDTH bits of a*b, carry=0.
- start while busy=1: ignored entirely, with no effect on the in-flight MUL. Operand or op changes during MUL are also ignored.
- start deasserted in IDLE: outputs hold and done=0.
- Arithmetic rules (all mod 2^WIDTH):
  - ADD: carry = carry-out bit WIDTH.
  - SUB: a-b; carry = borrow (a<b, unsigned).
  - AND/OR/XOR: carry=0.
  - SHL/SHR: logical shift by b[SHAMT_W-1:0].
    - Shift by 0: carry=0.
    - Otherwise carry = last bit shifted out.
- zero is always computed from the new result.
- Reset asserted mid-MUL: aborts immediately, returns to IDLE with all outputs 0, and no done is issued.
- done and busy are never both high in the same cycle.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined: MUL implemented as above.
- Undefined:
  - No accumulator or counter logic is generated, and busy is tied to 0.
  - op=MUL completes in 1 cycle with result=0, zero=1, carry=1. carry=1 flags an unsupported op; software checks it.

Decomposition:
- Package exec_pkg holds:
  - WIDTH default;
  - op_t enum, 3 bits: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, MUL=111;
  - state_t enum {IDLE, MUL}.
- One natural sub-module, exec_alu_comb: purely combinational single-cycle ops producing {carry, result}. exec_unit owns the registers, the FSM and the MUL datapath.

Test Plan:
- Reset:
  - Drive reset=0 mid-operation, then release -> all outputs 0 and state IDLE.
  - Start a MUL, assert reset at cycle 5 -> no done, busy=0 immediately.
- ADD overflow: start, op=ADD, a=0xFFFF, b=0x0001 -> next cycle done=1, write_en=1, result=0x0000, zero=1, carry=1.
- SUB borrow: a=0x0003, b=0x0005 -> result=0xFFFE, carry=1, zero=0.
- Shifts:
  - SHR, a=0x8001, b=0x0001 -> result=0x4000, carry=1.
  - SHL, a=0x8001, b=0x0010 (shamt 0) -> result=0x8001, carry=0.
- MUL:
  - a=0x0123, b=0x0045 -> busy high for exactly 16 cycles, then done with result=0x4E6F, carry=0.
  - A start with op=ADD issued at cycle 3 of the MUL is ignored, giving exactly one done.
- Back-to-back: AND then XOR on consecutive cycles (a=0xF0F0, b=0xFF00) -> consecutive done pulses with results 0xF000 then 0x0FF0.
- Build without EXEC_MUL_EN: op=MUL -> 1-cycle done, result=0, zero=1, carry=1, busy never high.
